// File: rtl/if_fetch_if.sv
// Instruction-memory port of the fetch stage: level request, one-cycle ack pulse.
interface if_fetch_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_rdata_i,
    input  mem_ack_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_rdata_i,
    output mem_ack_i
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the fetch FSM against a req/ack
// instruction memory and drives the IF/ID pipeline register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              br_flag_i,
  input  logic [31:0]       br_target_i,
  if_fetch_if.master        mem,
  output logic              if_stall_req_o,
  output logic [31:0]       id_pc_o,
  output logic [31:0]       id_inst_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_inst_q, id_inst_d;

  logic            req_c;
  logic            ack_c;
  logic            deliver_c;
  logic [XLEN-1:0] deliver_inst_c;
  logic [XLEN-1:0] br_tgt_c;
  logic            unused_stall;

  assign unused_stall = ^{stall[5:3], stall[0]};

  // State and pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      buf_q     <= NOP_INST;
      tgt_q     <= '0;
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      tgt_q     <= tgt_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
    end
  end

  // Next-state, PC and IF/ID update
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    buf_d          = buf_q;
    tgt_d          = tgt_q;
    id_pc_d        = id_pc_q;
    id_inst_d      = id_inst_q;
    deliver_c      = 1'b0;
    deliver_inst_c = buf_q;
    req_c          = !rst && (state_q != HOLD);
    ack_c          = req_c && mem.mem_ack_i;
    br_tgt_c       = {br_target_i[XLEN-1:2], 2'b00};

    case (state_q)
      FETCH: begin
        if (ack_c) begin
          if (br_flag_i) begin
            pc_d = br_tgt_c;
          end else if (!stall[1]) begin
            deliver_c      = 1'b1;
            deliver_inst_c = mem.mem_rdata_i;
            pc_d           = pc_q + PC_STEP;
          end else begin
            buf_d   = mem.mem_rdata_i;
            state_d = HOLD;
          end
        end else if (br_flag_i) begin
          tgt_d   = br_tgt_c;
          state_d = DROP;
        end
      end
      HOLD: begin
        if (br_flag_i) begin
          pc_d    = br_tgt_c;
          state_d = FETCH;
        end else if (!stall[1]) begin
          deliver_c = 1'b1;
          pc_d      = pc_q + PC_STEP;
          state_d   = FETCH;
        end
      end
      DROP: begin
        // Stale response still owed by memory; the latest redirect wins.
        if (br_flag_i) begin
          tgt_d = br_tgt_c;
        end
        if (ack_c) begin
          pc_d    = br_flag_i ? br_tgt_c : tgt_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (stall[1] && stall[2]) begin
      id_pc_d   = id_pc_q;
      id_inst_d = id_inst_q;
    end else if (br_flag_i) begin
      id_pc_d   = '0;
      id_inst_d = NOP_INST;
    end else if (deliver_c) begin
      id_pc_d   = pc_q;
      id_inst_d = deliver_inst_c;
    end else if (stall[1]) begin
      id_pc_d   = '0;
      id_inst_d = NOP_INST;
    end
  end

  assign mem.mem_req_o  = req_c;
  assign mem.mem_addr_o = pc_q;

  assign if_stall_req_o = !rst &&
                          (((state_q == FETCH) && !mem.mem_ack_i) || (state_q == DROP));

  assign id_pc_o   = id_pc_q;
  assign id_inst_o = id_inst_q;

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage RISC-V core. It owns the PC and runs a fetch state machine against a word-wide instruction memory with a req/ack handshake. It raises `if_stall_req_o` while no instruction is available and drives the IF/ID pipeline register. It consumes the 6-bit `stall` vector from the stall controller and branch redirects from ID.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`).

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `stall`  in  6: stall vector; bit1 = IF/ID hold, bit2 = ID hold. Bits 0 and 3–5 are unused.
- `br_flag_i`  in  1: redirect request this cycle.
- `br_target_i`  in  32: redirect target PC.
- `mem_req_o`  out  1: fetch request, level.
- `mem_addr_o`  out  32: fetch address, word-aligned.
- `mem_rdata_i`  in  32: fetched word, valid when `mem_ack_i` is high.
- `mem_ack_i`  in  1: one-cycle response pulse.
- `if_stall_req_o`  out  1: stall request to the stall controller.
- `id_pc_o`  out  32: IF/ID register, PC.
- `id_inst_o`  out  32: IF/ID register, instruction.

## Operation
- Registers:
  - `pc`.
  - `buf_inst`: one-entry holding buffer.
  - `tgt`: saved redirect target.
  - `state` ∈ {FETCH, HOLD, DROP}.
- Memory handshake:
  - `mem_req_o` stays high in FETCH and DROP, and is low in HOLD and during `rst`.
  - `mem_addr_o` = `pc` and stays stable until ack.
  - Memory may ack in any cycle where `mem_req_o` is high, including the first. `mem_ack_i` is ignored when `mem_req_o` is low.
- FETCH:
  - ack & `br_flag_i`: discard data; `pc`←`br_target_i`; stay in FETCH.
  - ack & !`stall[1]`: deliver {`pc`, `mem_rdata_i`} to IF/ID; `pc`←`pc`+4; stay in FETCH.
  - ack & `stall[1]`: `buf_inst`←`mem_rdata_i`; go to HOLD.
  - no ack & `br_flag_i`: `tgt`←`br_target_i`; go to DROP.
- HOLD:
  - `br_flag_i`: discard buffer; `pc`←`br_target_i`; go to FETCH.
  - !`stall[1]`: deliver {`pc`, `buf_inst`}; `pc`←`pc`+4; go to FETCH.
  - otherwise stay in HOLD.
- DROP:
  - `br_flag_i`: `tgt`←`br_target_i` (the latest redirect wins).
  - ack: discard data; `pc`←`tgt` (or `br_target_i` if `br_flag_i` is high in the same cycle); go to FETCH.
- `if_stall_req_o` = (FETCH & !`mem_ack_i`) | DROP. This is a combinational path from `mem_ack_i`.
- IF/ID register update priority:
  1. `rst`: load {0, `NOP_INST`}.
  2. `stall[1]` & `stall[2]`: hold.
  3. `br_flag_i`: load {0, `NOP_INST`} (flush).
  4. Deliver event: load {pc, inst}.
  5. `stall[1]` & !`stall[2]`: load {0, `NOP_INST`} (bubble).
  6. Otherwise: hold.
- A deliver event occurs only when `stall[1]`=0. `stall[0]` is ignored; PC advance is tied to IF/ID acceptance.
- PC arithmetic is a 32-bit wrap (32'hFFFF_FFFC+4 → 0). `br_target_i[1:0]` is forced to 0.

## Timing
- Reset values:
  - state = FETCH, `pc` = `RESET_PC`, `tgt` = 0, `buf_inst` = `NOP_INST`.
  - `id_pc_o` = 0, `id_inst_o` = `NOP_INST`.
  - `mem_req_o` = 0 and `if_stall_req_o` = 0 while `rst` is high.
  - `mem_addr_o` = `RESET_PC`.
- First request: `mem_req_o` rises in the first cycle with `rst` low.
- Deliver latency: ack in cycle n with `stall[1]`=0 → `id_inst_o` valid in n+1, and `mem_addr_o`=`pc`+4 in n+1. A 0-wait memory gives 1 instruction/cycle.
- Redirect latency: `br_flag_i` in cycle n from FETCH with ack, or from HOLD → `mem_addr_o` = target in n+1. From DROP or FETCH without ack → target is issued the cycle after the stale ack.
- Simultaneous events:
  - ack + branch: the branch wins and the data is discarded.
  - ack + `stall[1]`: data is buffered, never lost or refetched.
- Reset mid-fetch: the outstanding request is abandoned. The memory shares `rst` and must drop its pending ack.

## Test plan
- Reset release, memory acks in the same cycle as the request: `mem_addr_o` sequence 0, 4, 8; `id_inst_o` equals the memory words one cycle later; `if_stall_req_o` stays 0.
- Memory ack latency 3: `if_stall_req_o` is high for 2 cycles per fetch; ID sees `NOP_INST` bubbles between instructions; `id_pc_o` sequence 0, 4, 8.
- Ack while `stall`=6'b000111, released 2 cycles later: state goes to HOLD with `mem_req_o`=0; the buffered word is delivered with the correct pc; no address is refetched.
- `br_flag_i` with target 0x100 while a latency-3 fetch of 0x8 is pending: stale ack discarded, IF/ID flushed to NOP, next `mem_addr_o`=0x100, and no 0x8 instruction reaches ID.
- Two redirects (0x100 then 0x200) during DROP, plus ack coincident with a branch in FETCH: the final fetch address is 0x200 or the coincident target respectively.
- Assert `rst` mid-wait with pc=0x40: next cycle `mem_req_o`=0 and `id_inst_o`=`NOP_INST`; after release, fetch restarts at `RESET_PC`.
